// File: rtl/perm_comb_engine.sv
`default_nettype none
// ============================================================================
// Module   : perm_comb_engine
// Brief    : Sequential nPr / nCr engine with a multiplier and a restoring divider.
// Revision : 1.0
// ============================================================================
module perm_comb_engine #(
    parameter int NW = 4,
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [NW-1:0] din,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] answer,
    output logic          err,
    output logic          overflow
);

    localparam int PW = AW + NW;
    localparam int D  = AW + NW;
    localparam int CW = $clog2(D + 1);

    localparam logic [NW-1:0] C_ONE_NW   = NW'(1);
    localparam logic [CW-1:0] C_ONE_CNT  = CW'(1);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(D - 1);
    localparam logic [AW-1:0] C_ONE_AW   = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_M = 3'd1,
        S_CHECK  = 3'd2,
        S_MUL    = 3'd3,
        S_DIV    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [NW-1:0] r_n;
    logic [NW-1:0] r_m;
    logic [NW-1:0] r_k;
    logic [NW-1:0] r_kmax;
    logic          r_mode;
    logic [AW-1:0] r_acc;
    logic [PW-1:0] r_prod;
    logic [NW:0]   r_rem;
    logic [CW-1:0] r_cnt;
    logic          r_err_i;
    logic          r_ovf_i;

    logic          w_accept;
    logic [NW-1:0] w_nk;
    logic [PW-1:0] w_mul;
    logic          w_mul_ovf;
    logic [NW-1:0] w_nmm;
    logic [NW-1:0] w_kcalc;
    logic          w_m_gt_n;
    logic          w_trivial;
    logic [NW-1:0] w_k1;
    logic          w_last_step;
    logic [NW+1:0] w_trial;
    logic [NW+1:0] w_divisor;
    logic [NW+1:0] w_diff;
    logic          w_qbit;
    logic [NW:0]   w_rem_nxt;
    logic [PW-1:0] w_quot;
    logic          w_quot_ovf;
    logic          w_last_div;

    // A start coinciding with the done pulse is dropped; done is high only in IDLE.
    assign w_accept    = (r_state == S_IDLE) && start && !done;
    assign w_nk        = r_n - r_k;
    assign w_mul       = {{NW{1'b0}}, r_acc} * {{AW{1'b0}}, w_nk};
    assign w_mul_ovf   = |w_mul[PW-1:AW];
    assign w_nmm       = r_n - r_m;
    assign w_kcalc     = r_mode ? r_m : ((r_m <= w_nmm) ? r_m : w_nmm);
    assign w_m_gt_n    = (r_m > r_n);
    // K=0 covers M=0 and, for nCr, M=N; both yield 1 without any step.
    assign w_trivial   = w_m_gt_n || (w_kcalc == '0);
    assign w_k1        = r_k + C_ONE_NW;
    assign w_last_step = (w_k1 == r_kmax);

    // Restoring division: dividend shifts out the top, quotient bits shift in below.
    assign w_trial     = {r_rem, r_prod[PW-1]};
    assign w_divisor   = {2'b00, w_k1};
    assign w_qbit      = (w_trial >= w_divisor);
    assign w_diff      = w_trial - w_divisor;
    assign w_rem_nxt   = w_qbit ? w_diff[NW:0] : w_trial[NW:0];
    assign w_quot      = {r_prod[PW-2:0], w_qbit};
    assign w_quot_ovf  = |w_quot[PW-1:AW];
    assign w_last_div  = (r_cnt == C_CNT_LAST);

    assign busy        = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_LOAD_M;
            S_LOAD_M: w_next = S_CHECK;
            S_CHECK:  w_next = w_trivial ? S_DONE : S_MUL;
            S_MUL: begin
                if (!r_mode)          w_next = S_DIV;
                else if (w_last_step) w_next = S_DONE;
                else                  w_next = S_MUL;
            end
            S_DIV:    if (w_last_div) w_next = w_last_step ? S_DONE : S_MUL;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n      <= '0;
            r_m      <= '0;
            r_k      <= '0;
            r_kmax   <= '0;
            r_mode   <= 1'b0;
            r_acc    <= '0;
            r_prod   <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_err_i  <= 1'b0;
            r_ovf_i  <= 1'b0;
            done     <= 1'b0;
            answer   <= '0;
            err      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_n      <= din;
                        r_mode   <= mode;
                        r_err_i  <= 1'b0;
                        r_ovf_i  <= 1'b0;
                        err      <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                S_LOAD_M: r_m <= din;
                S_CHECK: begin
                    r_k     <= '0;
                    r_kmax  <= w_kcalc;
                    r_acc   <= w_m_gt_n ? '0 : C_ONE_AW;
                    r_err_i <= w_m_gt_n;
                end
                S_MUL: begin
                    if (r_mode) begin
                        r_acc <= w_mul_ovf ? '1 : w_mul[AW-1:0];
                        if (w_mul_ovf) r_ovf_i <= 1'b1;
                        r_k   <= w_k1;
                    end else begin
                        r_prod <= w_mul;
                        r_rem  <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_DIV: begin
                    r_prod <= w_quot;
                    r_rem  <= w_rem_nxt;
                    r_cnt  <= r_cnt + C_ONE_CNT;
                    if (w_last_div) begin
                        r_acc <= w_quot_ovf ? '1 : w_quot[AW-1:0];
                        if (w_quot_ovf) r_ovf_i <= 1'b1;
                        r_k   <= w_k1;
                    end
                end
                S_DONE: begin
                    done     <= 1'b1;
                    answer   <= r_acc;
                    err      <= r_err_i;
                    overflow <= r_ovf_i;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_perm_comb_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_perm_comb_engine
// Brief    : Scoreboard bench for perm_comb_engine with directed nPr/nCr vectors.
// Revision : 1.0
// ============================================================================
module tb_perm_comb_engine;

    localparam int NW = 4;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic [NW-1:0] din;
    logic          busy;
    logic          done;
    logic [AW-1:0] answer;
    logic          err;
    logic          overflow;

    perm_comb_engine #(.NW(NW), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .answer   (answer),
        .err      (err),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] ans;
        logic          e;
        logic          o;
        int            cyc;
        int            id;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_x;
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        if (done) begin
            chk("done_single_cycle", {63'b0, prev_done}, 64'd0);
            chk("busy_low_in_done", {63'b0, busy}, 64'd0);
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=answer %0h required=no done", answer);
            end else begin
                mon_x = sbq.pop_front();
                chk($sformatf("answer#%0d", mon_x.id), {48'b0, answer}, {48'b0, mon_x.ans});
                chk($sformatf("err#%0d", mon_x.id), {63'b0, err}, {63'b0, mon_x.e});
                chk($sformatf("overflow#%0d", mon_x.id), {63'b0, overflow}, {63'b0, mon_x.o});
                chk($sformatf("latency#%0d", mon_x.id), 64'(cyc), 64'(mon_x.cyc));
            end
        end
        prev_done = done;
    end

    // lat = index n of the edge En after which done is seen (E0 = accepting edge)
    task automatic issue(input logic md, input logic [NW-1:0] n, input logic [NW-1:0] m,
                         input logic push, input logic [AW-1:0] ea, input logic ee,
                         input logic eo, input int lat, input int id);
        exp_t x;
        @(negedge clk);
        start = 1'b1;
        mode  = md;
        din   = n;
        if (push) begin
            x.ans = ea;
            x.e   = ee;
            x.o   = eo;
            x.cyc = cyc + 1 + lat;
            x.id  = id;
            sbq.push_back(x);
        end
        @(negedge clk);
        start = 1'b0;
        din   = m;
    endtask

    task automatic wait_drain(input int budget, input int id);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout#%0d actual=%0d pending required=0 pending", id, sbq.size());
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic md, input logic [NW-1:0] n, input logic [NW-1:0] m,
                       input logic [AW-1:0] ea, input logic ee, input logic eo,
                       input int lat, input int id);
        issue(md, n, m, 1'b1, ea, ee, eo, lat, id);
        wait_drain(400, id);
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        din   = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_done", {63'b0, done}, 64'd0);
        chk("reset_answer", {48'b0, answer}, 64'd0);
        chk("reset_err", {63'b0, err}, 64'd0);
        chk("reset_overflow", {63'b0, overflow}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_release", {63'b0, busy}, 64'd0);

        run(1'b1,  4'd5,  4'd3, 16'd60,    1'b0, 1'b0,   6,  1);
        run(1'b0,  4'd5,  4'd3, 16'd10,    1'b0, 1'b0,  45,  2);
        run(1'b0,  4'd8,  4'd2, 16'd28,    1'b0, 1'b0,  45,  3);
        run(1'b0,  4'd6,  4'd3, 16'd20,    1'b0, 1'b0,  66,  4);
        run(1'b0,  4'd3,  4'd5, 16'd0,     1'b1, 1'b0,   3,  5);
        run(1'b0,  4'd7,  4'd0, 16'd1,     1'b0, 1'b0,   3,  6);
        run(1'b0,  4'd0,  4'd0, 16'd1,     1'b0, 1'b0,   3,  7);
        run(1'b1,  4'd4,  4'd5, 16'd0,     1'b1, 1'b0,   3,  8);
        run(1'b0, 4'd15, 4'd15, 16'd1,     1'b0, 1'b0,   3,  9);
        run(1'b0, 4'd15,  4'd7, 16'd6435,  1'b0, 1'b0, 150, 10);
        run(1'b1, 4'd10,  4'd5, 16'd30240, 1'b0, 1'b0,   8, 11);
        run(1'b1, 4'd15, 4'd15, 16'hFFFF,  1'b0, 1'b1,  18, 12);

        // Abort an nCr request in the middle of its first division
        issue(1'b0, 4'd5, 4'd3, 1'b0, 16'd0, 1'b0, 1'b0, 0, 13);
        repeat (8) @(negedge clk);
        chk("mid_div_busy", {63'b0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_done", {63'b0, done}, 64'd0);
        chk("abort_answer", {48'b0, answer}, 64'd0);
        chk("abort_err", {63'b0, err}, 64'd0);
        chk("abort_overflow", {63'b0, overflow}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_stays_idle", {63'b0, busy}, 64'd0);
        run(1'b1, 4'd5, 4'd3, 16'd60, 1'b0, 1'b0, 6, 14);

        // Spurious start pulses with new operands while busy
        issue(1'b1, 4'd5, 4'd3, 1'b1, 16'd60, 1'b0, 1'b0, 6, 15);
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        din   = 4'd7;
        @(negedge clk);
        din   = 4'd2;
        @(negedge clk);
        start = 1'b0;
        wait_drain(100, 15);
        repeat (3) @(negedge clk);
        chk("no_queued_start", {63'b0, busy}, 64'd0);

        // Start held during the done cycle must not be accepted
        issue(1'b0, 4'd6, 4'd3, 1'b1, 16'd20, 1'b0, 1'b0, 66, 16);
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen#16", {63'b0, done}, 64'd1);
        start = 1'b1;
        mode  = 1'b1;
        din   = 4'd9;
        @(negedge clk);
        start = 1'b0;
        din   = 4'd0;
        @(negedge clk);
        chk("start_in_done_ignored", {63'b0, busy}, 64'd0);
        repeat (3) @(negedge clk);
        chk("answer_hold", {48'b0, answer}, 64'd20);
        wait_drain(10, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
